// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver / panel emulator.
// Samples RGB0/RGB1/ADDR/SCLK/LATCH/BLANK through a synchroniser, rebuilds
// each shifted line in a ping-pong line buffer and streams committed lines
// out as pixel beats on a valid/ready interface.
//
// Ports:
//   CLK, resetn          system clock (>= 4x SCLK), async active-low reset
//   RGB0, RGB1           upper/lower pixel bits {B,G,R}
//   ADDR                 row address
//   SCLK, LATCH, BLANK   HUB75 shift clock, line commit, output enable
//   clear_err            synchronous clear of the sticky flags
//   px_valid/px_ready    pixel beat handshake
//   px_rgb0, px_rgb1     pixel data of the current beat
//   px_row, px_col       row and column of the current beat
//   px_last              final column of the line
//   blank_sync           synchronised BLANK
//   err_short, err_long, drop_line   sticky error flags
//   frame_count          (HUB75_RX_STATS_EN only) wrapped row-0 counter
//
// Optional feature: define HUB75_RX_STATS_EN to add frame_count.
module hub75_rx #(
    parameter int          WIDTH       = 64,
    parameter int          ADDR_W      = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     CLK,
    input  logic                     resetn,
    input  logic [2:0]               RGB0,
    input  logic [2:0]               RGB1,
    input  logic [ADDR_W-1:0]        ADDR,
    input  logic                     SCLK,
    input  logic                     LATCH,
    input  logic                     BLANK,
    input  logic                     clear_err,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [2:0]               px_rgb0,
    output logic [2:0]               px_rgb1,
    output logic [ADDR_W-1:0]        px_row,
    output logic [$clog2(WIDTH)-1:0] px_col,
    output logic                     px_last,
    output logic                     blank_sync,
    output logic                     err_short,
    output logic                     err_long,
    output logic                     drop_line
`ifdef HUB75_RX_STATS_EN
    ,
    output logic [15:0]              frame_count
`endif
);

    localparam int              CW       = $clog2(WIDTH);
    localparam int              SW       = ADDR_W + 9;
    localparam logic [CW:0]     COL_FULL = (CW+1)'(WIDTH);
    localparam logic [CW-1:0]   COL_LAST = CW'(WIDTH - 1);
    localparam logic [0:0]      ST_IDLE   = 1'b0;
    localparam logic [0:0]      ST_STREAM = 1'b1;

    // Synchroniser
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] sync_s;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {BLANK, LATCH, SCLK, ADDR, RGB1, RGB0};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s     = sync_q[SYNC_STAGES-1];
    assign blank_sync = sync_s[ADDR_W+8];

    // Edge detection, registered together with the data it qualifies so the
    // capture/commit stage sees pulse, pixel and address aligned.
    logic              sclk_h, latch_h, sclk_rise_q, latch_rise_q;
    logic [5:0]        rgb_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sclk_h       <= 1'b0;
            latch_h      <= 1'b0;
            sclk_rise_q  <= 1'b0;
            latch_rise_q <= 1'b0;
            rgb_q        <= '0;
            addr_q       <= '0;
        end else begin
            sclk_h       <= sync_s[ADDR_W+6];
            latch_h      <= sync_s[ADDR_W+7];
            sclk_rise_q  <= sync_s[ADDR_W+6] & ~sclk_h;
            latch_rise_q <= sync_s[ADDR_W+7] & ~latch_h;
            rgb_q        <= sync_s[5:0];
            addr_q       <= sync_s[ADDR_W+5:6];
        end
    end

    // Capture / commit state
    logic [CW:0]       col_cnt;
    logic              line_bad;   // a column arrived while the fill buffer was still held
    logic [1:0]        full;
    logic              fill_sel, drain_sel;
    logic [ADDR_W-1:0] row_buf [2];
    logic [0:0]        state;
    logic [CW-1:0]     rd_col;
    logic [5:0]        mem [2**(CW+1)];

    logic        cap, overrun, wr_en, bad_next, line_end;
    logic        commit, drop, short_ev, fire;
    logic [CW:0] col_next;

    // Capture is applied before the commit decision, so a same-cycle
    // SCLK/LATCH pair commits with the updated column count.
    always_comb begin
        cap      = sclk_rise_q && (col_cnt < COL_FULL);
        overrun  = sclk_rise_q && !(col_cnt < COL_FULL);
        wr_en    = cap && !full[fill_sel];
        col_next = cap ? col_cnt + 1'b1 : col_cnt;
        bad_next = line_bad | (cap & full[fill_sel]);
        line_end = latch_rise_q && (col_next != '0);
        short_ev = line_end && (col_next < COL_FULL);
        drop     = line_end && (col_next == COL_FULL) && (bad_next || full[fill_sel]);
        commit   = line_end && (col_next == COL_FULL) && !(bad_next || full[fill_sel]);
        fire     = (state == ST_STREAM) && px_ready;
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[{fill_sel, col_cnt[CW-1:0]}] <= rgb_q;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            col_cnt    <= '0;
            line_bad   <= 1'b0;
            full       <= '0;
            fill_sel   <= 1'b0;
            drain_sel  <= 1'b0;
            row_buf[0] <= '0;
            row_buf[1] <= '0;
            state      <= ST_IDLE;
            rd_col     <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            drop_line  <= 1'b0;
        end else begin
            col_cnt  <= line_end ? '0 : col_next;
            line_bad <= line_end ? 1'b0 : bad_next;

            if (commit) begin
                full[fill_sel]    <= 1'b1;
                row_buf[fill_sel] <= addr_q;
                fill_sel          <= ~fill_sel;
            end

            case (state)
                ST_IDLE: begin
                    if (full[drain_sel]) state <= ST_STREAM;
                end
                default: begin
                    if (fire) begin
                        if (rd_col == COL_LAST) begin
                            full[drain_sel] <= 1'b0;
                            drain_sel       <= ~drain_sel;
                            rd_col          <= '0;
                            if (!full[~drain_sel]) state <= ST_IDLE;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
            endcase

            err_short <= short_ev | (err_short & ~clear_err);
            err_long  <= overrun  | (err_long  & ~clear_err);
            drop_line <= drop     | (drop_line & ~clear_err);
        end
    end

    // Pixel output
    logic [5:0] rd_word;

    always_comb begin
        rd_word  = mem[{drain_sel, rd_col}];
        px_valid = (state == ST_STREAM);
        px_rgb0  = px_valid ? rd_word[2:0] : '0;
        px_rgb1  = px_valid ? rd_word[5:3] : '0;
        px_row   = px_valid ? row_buf[drain_sel] : '0;
        px_col   = rd_col;
        px_last  = px_valid && (rd_col == COL_LAST);
    end

`ifdef HUB75_RX_STATS_EN
    logic [ADDR_W-1:0] prev_row;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            frame_count <= '0;
            prev_row    <= '0;
        end else if (commit) begin
            if ((addr_q == '0) && (prev_row == '1)) frame_count <= frame_count + 16'd1;
            prev_row <= addr_q;
        end
    end
`endif

endmodule
